// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-slot TDM demultiplexer.
//   tdm_state_t : frame alignment state (HUNT searching for sync, LOCKED aligned)
//   N_SLOTS     : slots per frame
//   SLOT_W      : width of a slot index
//   FCNT_W      : width of the published-frame counter
package tdm_pkg;

  typedef enum logic [0:0] {
    HUNT,
    LOCKED
  } tdm_state_t;

  localparam int unsigned N_SLOTS = 4;
  localparam int unsigned SLOT_W  = 2;
  localparam int unsigned FCNT_W  = 8;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position counter for the TDM demultiplexer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance to the next slot (3 wraps to 0)
//   load0      : slot 0 was just captured, next slot is 1
//   clr        : return to slot 0
//   slot       : index of the next slot to be captured
//   last       : high while the next slot is the final slot of the frame
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load0,
  input  logic              clr,
  output logic [SLOT_W-1:0] slot,
  output logic              last
);

  logic [SLOT_W-1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (load0) begin
      slot_d = SLOT_W'(1);
    end else if (inc) begin
      slot_d = slot_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;
  assign last = (slot_q == SLOT_W'(N_SLOTS - 1));

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot time-division demultiplexer.
// Rebuilds each 4-slot frame of a serial TDM stream into a parallel word, tracks
// frame alignment from the sync marker and flags sync violations.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : slot strobe, din/sync are only sampled when high
//   sync       : frame marker, expected with the slot-0 strobe
//   din        : serial slot data
//   q          : last complete frame, q[W*k +: W] is slot k
//   q_valid    : one-cycle pulse when q is updated
//   slot       : index of the next slot to be captured
//   locked     : high while frame-aligned
//   sync_err   : one-cycle pulse on an early or missing sync
//   frame_cnt  : number of published frames, wrapping
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync,
  input  logic [W-1:0]      din,
  output logic [4*W-1:0]    q,
  output logic              q_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              locked,
  output logic              sync_err,
  output logic [FCNT_W-1:0] frame_cnt
);

  tdm_state_t state_q, state_d;

  logic              last;
  logic              ctr_inc, ctr_load0, ctr_clr;
  logic              shadow_we, publish, err;
  logic [SLOT_W-1:0] shadow_idx;

  // Slots 0..2 wait here; slot 3 goes straight into q on publish.
  logic [N_SLOTS-2:0][W-1:0] shadow_q;
  logic [4*W-1:0]            q_q;
  logic                      q_valid_q, sync_err_q;
  logic [FCNT_W-1:0]         frame_cnt_q;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctr_inc),
    .load0 (ctr_load0),
    .clr   (ctr_clr),
    .slot  (slot),
    .last  (last)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        HUNT:    if (sync) state_d = LOCKED;
        LOCKED:  if (!sync && slot == '0) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // Per-strobe actions
  always_comb begin
    ctr_inc    = 1'b0;
    ctr_load0  = 1'b0;
    ctr_clr    = 1'b0;
    shadow_we  = 1'b0;
    publish    = 1'b0;
    err        = 1'b0;
    shadow_idx = sync ? '0 : slot;
    if (en) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            shadow_we = 1'b1;
            ctr_load0 = 1'b1;
          end
        end
        LOCKED: begin
          if (sync) begin
            // Early sync drops the partial frame and restarts at slot 0.
            err       = (slot != '0);
            shadow_we = 1'b1;
            ctr_load0 = 1'b1;
          end else if (slot == '0) begin
            err     = 1'b1;
            ctr_clr = 1'b1;
          end else if (last) begin
            publish = 1'b1;
            ctr_inc = 1'b1;
          end else begin
            shadow_we = 1'b1;
            ctr_inc   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Shadow, output word and frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      sync_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      q_valid_q  <= publish;
      sync_err_q <= err;
      if (shadow_we) begin
        shadow_q[shadow_idx] <= din;
      end
      if (publish) begin
        q_q         <= {din, shadow_q};
        frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
      end
    end
  end

  assign q         = q_q;
  assign q_valid   = q_valid_q;
  assign sync_err  = sync_err_q;
  assign frame_cnt = frame_cnt_q;
  assign locked    = (state_q == LOCKED);

endmodule
